// File: rtl/ternary_serial_adder_if.sv
// ternary_serial_adder_if: start/operand request and result bundle for the serial ternary adder.
interface ternary_serial_adder_if #(parameter int N = 4);
  logic start;
  logic [2*N-1:0] a;
  logic [2*N-1:0] b;
  logic cin;
  logic [2*N-1:0] sum;
  logic cout;
  logic busy;
  logic done;
  logic err;
  modport master (output start, a, b, cin, input sum, cout, busy, done, err);
  modport slave (input start, a, b, cin, output sum, cout, busy, done, err);
endinterface

// File: rtl/ternary_serial_adder.sv
// ternary_serial_adder: adds two N-trit binary-coded ternary operands one trit per clock, LSB first.
module ternary_serial_adder #(
  parameter int N = 4,
  parameter int IDXW = 3
) (
  input logic clk,
  input logic reset,
  ternary_serial_adder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [2*N-1:0] a_q, b_q, sum_q;
  logic [IDXW-1:0] idx_q;
  logic carry_q, cout_q, err_q;
  logic [1:0] ra, rb, da, db, digit;
  logic [2:0] t;
  logic last, accept;
  // Invalid 11 codes count as zero so the sum never carries an illegal trit.
  always_comb begin
    ra = a_q[{idx_q, 1'b0} +: 2];
    rb = b_q[{idx_q, 1'b0} +: 2];
    da = ra == 2'b11 ? 2'b00 : ra;
    db = rb == 2'b11 ? 2'b00 : rb;
    t = {1'b0, da} + {1'b0, db} + {2'b00, carry_q};
    digit = t >= 3'd3 ? 2'(t - 3'd3) : t[1:0];
    last = idx_q == IDXW'(N - 1);
    accept = bus.start && state_q != RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == RUN ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
  end
  always_comb begin
    bus.busy = state_q == RUN;
    bus.done = state_q == DONE;
    bus.sum = sum_q;
    bus.cout = cout_q;
    bus.err = err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      idx_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      a_q <= bus.a;
      b_q <= bus.b;
      carry_q <= bus.cin;
      idx_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
      err_q <= 1'b0;
    end else if (state_q == RUN) begin
      sum_q[{idx_q, 1'b0} +: 2] <= digit;
      carry_q <= t >= 3'd3;
      err_q <= err_q | (ra == 2'b11) | (rb == 2'b11);
      if (last) cout_q <= t >= 3'd3;
      else idx_q <= idx_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_ternary_serial_adder.sv
// tb_ternary_serial_adder: table vectors, handshake corner sequences and random ops against an integer model.
module tb_ternary_serial_adder;
  localparam int N = 4;
  localparam int W = 2 * N;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic cin;
    logic [W-1:0] sum;
    logic cout;
    logic err;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ternary_serial_adder_if #(.N(N)) bus ();
  ternary_serial_adder #(.N(N), .IDXW(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: integer values of both operands plus carry, re-expanded in base 3.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                output logic [W-1:0] s, output logic co, output logic e);
    int va, vb, p, tot;
    logic [1:0] x, y;
    va = 0; vb = 0; p = 1; e = 1'b0;
    for (int i = 0; i < N; i++) begin
      x = a[2*i +: 2];
      y = b[2*i +: 2];
      if (x == 2'b11) begin e = 1'b1; x = 2'b00; end
      if (y == 2'b11) begin e = 1'b1; y = 2'b00; end
      va += int'(x) * p;
      vb += int'(y) * p;
      p *= 3;
    end
    tot = va + vb + int'(c);
    s = '0;
    for (int i = 0; i < N; i++) begin
      s[2*i +: 2] = 2'(tot % 3);
      tot = tot / 3;
    end
    co = tot[0];
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.done && cyc < 4 * N) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", {31'd0, bus.done}, 32'd1);
  endtask

  task automatic do_op(input vec_t v, input string nm);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1; bus.a = v.a; bus.b = v.b; bus.cin = v.cin;
    @(negedge clk);
    bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
    chk({nm, "_busy"}, {31'd0, bus.busy}, 32'd1);
    wait_done(cyc);
    chk({nm, "_latency"}, cyc, N);
    chk({nm, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    chk({nm, "_sum"}, {24'd0, bus.sum}, {24'd0, v.sum});
    chk({nm, "_cout"}, {31'd0, bus.cout}, {31'd0, v.cout});
    chk({nm, "_err"}, {31'd0, bus.err}, {31'd0, v.err});
    @(negedge clk);
    chk({nm, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({nm, "_sum_hold"}, {24'd0, bus.sum}, {24'd0, v.sum});
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    int cyc;
    tbl[0] = '{8'h66, 8'h19, 1'b0, 8'h94, 1'b0, 1'b0};
    tbl[1] = '{8'hAA, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[3] = '{8'h03, 8'h01, 1'b0, 8'h01, 1'b0, 1'b1};
    tbl[4] = '{8'h66, 8'h19, 1'b0, 8'h94, 1'b0, 1'b0};
    tbl[5] = '{8'hAA, 8'hAA, 1'b1, 8'hAA, 1'b1, 1'b0};
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sum", {24'd0, bus.sum}, 32'd0);
    chk("rst_cout", {31'd0, bus.cout}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    reset = 1'b0;
    foreach (tbl[i]) do_op(tbl[i], $sformatf("vec%0d", i));
    // Start while busy is ignored; start during DONE is accepted.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h66; bus.b = 8'h19; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'hAA; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc);
    chk("busy_start_sum", {24'd0, bus.sum}, 32'h94);
    chk("busy_start_cout", {31'd0, bus.cout}, 32'd0);
    bus.start = 1'b1; bus.a = 8'h00; bus.b = 8'h00; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_start_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(cyc);
    chk("done_start_latency", cyc, N);
    chk("done_start_sum", {24'd0, bus.sum}, 32'h01);
    @(negedge clk);
    // Reset two cycles into an operation.
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h01; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_sum", {24'd0, bus.sum}, 32'd0);
    chk("midrst_cout", {31'd0, bus.cout}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_err", {31'd0, bus.err}, 32'd0);
    cyc = 0;
    repeat (N + 2) begin
      @(negedge clk);
      cyc += int'(bus.done) + int'(bus.busy);
    end
    chk("midrst_no_done", cyc, 0);
    do_op(tbl[0], "post_rst");
    for (int i = 0; i < 40; i++) begin
      v.a = W'($urandom);
      v.b = W'($urandom);
      v.cin = 1'($urandom);
      model(v.a, v.b, v.cin, v.sum, v.cout, v.err);
      do_op(v, $sformatf("rnd%0d", i));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
